// File: rtl/seq_digit_mult_pkg.sv
// Shared types and constants for the sequential digit-serial multiplier.
package seq_digit_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int unsigned DIGIT_W = 2;
    localparam int unsigned PP_W    = 4;

    // Counter width able to hold nd-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned nd);
        return (nd > 1) ? $clog2(nd) : 1;
    endfunction

endpackage

// File: rtl/seq_digit_mult_mult2.sv
// Gate-level 2x2 unsigned multiplier core; purely combinational.
module Mult2 (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic [3:0] p_c
);

    logic a0b0, a1b0, a0b1, a1b1, c1;

    assign a0b0 = a_i[0] & b_i[0];
    assign a1b0 = a_i[1] & b_i[0];
    assign a0b1 = a_i[0] & b_i[1];
    assign a1b1 = a_i[1] & b_i[1];
    assign c1   = a1b0 & a0b1;

    assign p_c[0] = a0b0;
    assign p_c[1] = a1b0 ^ a0b1;
    assign p_c[2] = a1b1 ^ c1;
    assign p_c[3] = a1b1 & c1;

endmodule

// File: rtl/seq_digit_mult.sv
// WIDTH x WIDTH unsigned multiplier: one 2-bit digit pair per clock through a 2x2 core,
// shifted and accumulated; start/busy/done handshake.
module seq_digit_mult
    import seq_digit_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned ND     = WIDTH / DIGIT_W;
    localparam int unsigned CNT_W  = cnt_width(ND);
    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ND - 1);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [CNT_W-1:0]    i_q, i_d;
    logic [CNT_W-1:0]    j_q, j_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [PROD_W-1:0]   product_q, product_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [DIGIT_W-1:0]  a_dig_c, b_dig_c;
    logic [PP_W-1:0]     pp_c;
    logic [PROD_W-1:0]   pp_sh_c;
    logic                last_pair_c;

    // Digit-select muxes feeding the 2x2 core, and the weight shift of its result.
    assign a_dig_c     = DIGIT_W'(a_q >> (DIGIT_W * 32'(i_q)));
    assign b_dig_c     = DIGIT_W'(b_q >> (DIGIT_W * 32'(j_q)));
    assign pp_sh_c     = PROD_W'(pp_c) << (DIGIT_W * (32'(i_q) + 32'(j_q)));
    assign last_pair_c = (i_q == LAST) && (j_q == LAST);

    Mult2 u_core (
        .a_i (a_dig_c),
        .b_i (b_dig_c),
        .p_c (pp_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            acc_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            i_q       <= i_d;
            j_q       <= j_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        i_d       = i_q;
        j_d       = j_q;
        acc_d     = acc_q;
        product_d = product_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    i_d     = '0;
                    j_d     = '0;
                    acc_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = acc_q + pp_sh_c;
                // j is the inner digit index; i advances when j wraps.
                if (j_q == LAST) begin
                    j_d = '0;
                    i_d = i_q + CNT_W'(1);
                end else begin
                    j_d = j_q + CNT_W'(1);
                end
                if (last_pair_c) begin
                    i_d     = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                product_d = acc_q;
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_digit_mult.sv
// Self-checking bench for seq_digit_mult: cycle-level reference model plus directed
// and random stimulus at WIDTH=8, and exhaustive sweeps at WIDTH=2 and WIDTH=4.
module tb_seq_digit_mult;

    localparam int ND  = 4;
    localparam int LAT = ND * ND + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  a, b;
    logic        busy, done;
    logic [15:0] product;

    logic        s2, busy2, done2;
    logic [1:0]  a2, b2;
    logic [3:0]  p2;
    logic        s4, busy4, done4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    seq_digit_mult #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product)
    );

    seq_digit_mult #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(s2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .product(p2)
    );

    seq_digit_mult #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .product(p4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: n counts cycles since acceptance; busy for n=0..LAT-1,
    // done and the new product at n=LAT, then free to accept again.
    int          m_n;
    logic        m_busy, m_done;
    logic [15:0] m_prod, m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n    = -1;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_prod = 16'd0;
            m_pend = 16'd0;
        end else begin
            if (m_n < 0 || m_n == LAT) begin
                if (start) begin
                    m_n    = 0;
                    m_pend = 16'(a) * 16'(b);
                end else begin
                    m_n = -1;
                end
            end else begin
                m_n++;
            end
            m_busy = (m_n >= 0) && (m_n < LAT);
            m_done = (m_n == LAT);
            if (m_done) m_prod = m_pend;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_busy", 32'(busy), 32'(m_busy));
            chk("cyc_done", 32'(done), 32'(m_done));
            chk("cyc_product", 32'(product), 32'(m_prod));
        end
    end

    // Call at a falling edge; returns at the falling edge inside the done cycle.
    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb,
                          input logic [15:0] exp, input string nm);
        int k;
        start = 1'b1;
        a     = xa;
        b     = xb;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_busy"}, 32'(busy), 32'd1);
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_latency"}, 32'(k), 32'(LAT));
        chk({nm, "_product"}, 32'(product), 32'(exp));
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 5))
            0:       return 8'h00;
            1:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        int k;
        rst_n = 1'b1;
        start = 1'b0; a = '0; b = '0;
        s2 = 1'b0; a2 = '0; b2 = '0;
        s4 = 1'b0; a4 = '0; b4 = '0;
        #1 rst_n = 1'b0;
        #11;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_product_w2", 32'(p2), 32'd0);
        chk("rst_product_w4", 32'(p4), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // Basic product and latency
        run_op(8'd3, 8'd2, 16'd6, "t1");
        chk("t1_model_pin", 32'(m_prod), 32'd6);
        @(negedge clk);

        // Max operands; single done pulse and busy released
        run_op(8'hFF, 8'hFF, 16'hFE01, "t2");
        chk("t2_done_high", 32'(done), 32'd1);
        @(negedge clk);
        chk("t2_done_low", 32'(done), 32'd0);
        chk("t2_busy_low", 32'(busy), 32'd0);
        chk("t2_model_pin", 32'(m_prod), 32'hFE01);

        run_op(8'h00, 8'hA5, 16'h0000, "t3a");
        @(negedge clk);
        run_op(8'h80, 8'h02, 16'h0100, "t3b");
        @(negedge clk);

        // Start during RUN must be ignored
        start = 1'b1; a = 8'd5; b = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; a = 8'd9; b = 8'd9;
        @(negedge clk);
        start = 1'b0; a = 8'd0; b = 8'd0;
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_product", 32'(product), 32'd35);
        @(negedge clk);
        chk("t4_idle_after", 32'(busy), 32'd0);

        // Reset in the middle of RUN
        start = 1'b1; a = 8'd200; b = 8'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_done", 32'(done), 32'd0);
        chk("t5_rst_product", 32'(product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8'd12, 8'd12, 16'd144, "t5");

        // Back-to-back: start the cycle after done
        @(negedge clk);
        run_op(8'd13, 8'd11, 16'd143, "t6a");
        @(negedge clk);
        run_op(8'hF0, 8'h0F, 16'h0E10, "t6b");

        // Random traffic, including spurious starts while busy
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            a     = pick();
            b     = pick();
        end
        start = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        cmp_en = 1'b0;

        // Exhaustive WIDTH=2 (one digit pair, done two cycles after acceptance)
        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
                @(negedge clk);
                s2 = 1'b1; a2 = 2'(x); b2 = 2'(y);
                @(negedge clk);
                s2 = 1'b0;
                k = 0;
                while (!done2 && k < 20) begin
                    @(negedge clk);
                    k++;
                end
                chk("w2_latency", 32'(k), 32'd2);
                chk("w2_product", 32'(p2), 32'(x * y));
            end
        end

        // Exhaustive WIDTH=4 (four digit pairs)
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                @(negedge clk);
                s4 = 1'b1; a4 = 4'(x); b4 = 4'(y);
                @(negedge clk);
                s4 = 1'b0;
                k = 0;
                while (!done4 && k < 20) begin
                    @(negedge clk);
                    k++;
                end
                chk("w4_latency", 32'(k), 32'd5);
                chk("w4_product", 32'(p4), 32'(x * y));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
